instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Sequences the instruction memory: owns the 64-bit PC, drives the instrMem address, and
//  enqueues each fetched word into a small FIFO toward decode under a valid/ready handshake.
//  Handles branch/jump redirects with a queue flush, and stops at a program end address.
//  Sits between instrMem (combinational read) and the decode stage.
// PARAMETERS
//  RESET_PC  64'd40  PC loaded on reset (first program word)
//  END_PC    64'd84  last valid fetch address; fetch stops after enqueuing it
//  DEPTH     2       fetch-queue entries (power of two, >=2)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  reset        in   1   synchronous, active-high reset
//  start        in   1   leave IDLE and begin fetching
//  imem_addr    out  64  address to instrMem = PC (combinational from PC register)
//  imem_instr   in   32  instruction word returned by instrMem, same cycle
//  redir_valid  in   1   redirect request (taken branch/jump)
//  redir_pc     in   64  redirect target
//  id_valid     out  1   queue head valid toward decode
//  id_instr     out  32  queue head instruction
//  id_pc        out  64  PC of queue head instruction
//  id_ready     in   1   decode accepts head when id_valid & id_ready
//  busy         out  1   state is RUN or queue non-empty
//  misalign_err out  1   sticky: redirect target with pc[1:0]!=0 seen
// BEHAVIOUR
//  Reset: PC=RESET_PC, state=IDLE, queue empty, id_valid=0, id_instr=0, id_pc=0, busy=0,
//   misalign_err=0. Reset wins over every other input in the same cycle, incl. mid-fetch.
//  States: IDLE -(start)-> RUN; RUN -(enqueue at PC==END_PC)-> DONE;
//   RUN/DONE -(misaligned redirect)-> HALT; DONE -(aligned redirect)-> RUN.
//   HALT exits only on reset. IDLE: redirect ignored; start ignored in RUN/DONE/HALT.
//  Fetch: in RUN, if queue not full and no redirect this cycle, push {PC, imem_instr} and
//   PC<=PC+4. Queue full -> PC holds, no push (stall). One push per cycle max.
//  Latency: start seen at edge N -> RUN; first push at edge N+1; id_valid=1 after edge N+1.
//  Dequeue: id_valid & id_ready pops head at the edge; push and pop same cycle on a full
//   queue is NOT allowed (full gates push by registered count; pop frees a slot next cycle).
//  Redirect (aligned, RUN or DONE): at edge, queue flushed (all entries dropped, including
//   one being pushed), PC<=redir_pc, state RUN. A simultaneous pop completes (decode owns
//   that word); id_valid=0 the following cycle; first post-redirect push one cycle later.
//  Redirect misaligned: queue flushed, PC unchanged, misalign_err<=1, state HALT.
//  Redirect has priority over fetch; redirect to END_PC enqueues it then goes DONE.
//  PC arithmetic: unsigned 64-bit, +4 wraps modulo 2^64 (no error).
//  Queue: DEPTH entries, wrap-around read/write pointers, count width $clog2(DEPTH)+1.
//  busy = (state==RUN) | (count!=0). id_* outputs hold last head value when id_valid=0.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds ports perf_fetch[31:0], perf_stall[31:0] (out, reset 0):
//   perf_fetch += 1 per push; perf_stall += 1 per RUN cycle with queue full; both saturate
//   at 32'hFFFF_FFFF; flush does not clear them. Undefined: ports and counters absent,
//   all other behaviour identical.
// TESTING
//  Reset, start, id_ready=1 -> id_pc 40,44,...,84 consecutive, first id_instr=32'h06402083,
//   state DONE after 84, busy drops once queue drains.
//  id_ready=0 after start -> exactly DEPTH pushes (PC 40,44), PC holds 48, id_pc stays 40.
//  Redirect redir_pc=64 while queue holds 52,56 -> both dropped, next id_pc=64 (32'h005080B3).
//  Redirect redir_pc=66 -> misalign_err=1, HALT, id_valid=0, no further fetch until reset.
//  Reset asserted mid-RUN with queue full -> next cycle PC=40, id_valid=0, state IDLE.
//  FETCH_PERF_EN: full program with 3 stall cycles -> perf_fetch=12, perf_stall=3.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
//   Instruction fetch sequencer. Owns the 64-bit PC, presents it to a
//   combinational instruction memory and pushes {PC, word} into a small
//   fetch queue that decode drains under a valid/ready handshake. Redirects
//   (taken branch/jump) flush the queue; a misaligned target halts the
//   fetcher until reset. Fetch stops after the word at END_PC is queued.
//
//   Optional feature macro: FETCH_PERF_EN
//     When defined, adds perf_fetch/perf_stall saturating event counters.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start                 leave IDLE and begin fetching
//   imem_addr/imem_instr  instruction memory address (= PC) and returned word
//   redir_valid/redir_pc  redirect request and its target
//   id_valid/id_instr/id_pc/id_ready  queue head toward decode
//   busy                  fetching or queue still holds words
//   misalign_err          sticky, set by a misaligned redirect target
//   perf_fetch/perf_stall (FETCH_PERF_EN only) push count, full-stall count
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for start, redirects ignored
// RUN   | fetching one word per cycle while the queue has room
// DONE  | END_PC queued, waiting for a redirect
// HALT  | misaligned redirect seen, only reset leaves
module instr_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'd40,
    parameter logic [63:0] END_PC   = 64'd84,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redir_valid,
    input  logic [63:0] redir_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc,
    input  logic        id_ready,
    output logic        busy,
    output logic        misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t          state;
    logic [63:0]     pc;
    logic [63:0]     q_pc    [DEPTH];
    logic [31:0]     q_instr [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            active;
    logic            redir_ok;
    logic            redir_bad;
    logic            flush;
    logic            full;
    logic            pop;
    logic            push;
    logic [CW-1:0]   count_after_pop;
    logic [CW-1:0]   count_next;
    logic [PW-1:0]   rd_next;
    logic [63:0]     head_pc;
    logic [31:0]     head_instr;

    assign imem_addr = pc;
    assign busy      = (state == S_RUN) || (count != '0);

    always_comb begin
        active          = (state == S_RUN) || (state == S_DONE);
        redir_ok        = redir_valid && active && (redir_pc[1:0] == 2'b00);
        redir_bad       = redir_valid && active && (redir_pc[1:0] != 2'b00);
        flush           = redir_ok || redir_bad;
        // Full is judged on the registered count: a pop this cycle does not
        // make room for a push until the next cycle.
        full            = (count == CW'(DEPTH));
        pop             = id_valid && id_ready;
        push            = (state == S_RUN) && !full && !flush;
        count_after_pop = count - CW'(pop);
        rd_next         = rd_ptr + PW'(pop);
        count_next      = flush ? '0 : (count_after_pop + CW'(push));
        // When nothing older survives the pop, the new head is the word
        // being pushed this cycle.
        if (count_after_pop == '0) begin
            head_pc    = pc;
            head_instr = imem_instr;
        end else begin
            head_pc    = q_pc[rd_next];
            head_instr = q_instr[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_instr     <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (push) begin
                q_pc[wr_ptr]    <= pc;
                q_instr[wr_ptr] <= imem_instr;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                rd_ptr <= rd_next;
                wr_ptr <= wr_ptr + PW'(push);
            end
            count    <= count_next;
            id_valid <= (count_next != '0);
            // Head outputs hold their last value while the queue is empty.
            if (count_next != '0) begin
                id_pc    <= head_pc;
                id_instr <= head_instr;
            end

            case (state)
                S_IDLE: begin
                    if (start) state <= S_RUN;
                end
                S_RUN, S_DONE: begin
                    if (redir_ok) begin
                        pc    <= redir_pc;
                        state <= S_RUN;
                    end else if (redir_bad) begin
                        misalign_err <= 1'b1;
                        state        <= S_HALT;
                    end else if (push) begin
                        pc <= pc + 64'd4;
                        if (pc == END_PC) state <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            if (push && (perf_fetch != 32'hFFFF_FFFF))
                perf_fetch <= perf_fetch + 32'd1;
            if ((state == S_RUN) && full && (perf_stall != 32'hFFFF_FFFF))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

    localparam logic [63:0] RESET_PC = 64'd40;
    localparam logic [63:0] END_PC   = 64'd84;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic        id_ready;
    logic        busy;
    logic        misalign_err;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    int checks   = 0;
    int failures = 0;

    instr_fetch_ctrl #(.RESET_PC(RESET_PC), .END_PC(END_PC), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_ready     (id_ready),
        .busy         (busy),
        .misalign_err (misalign_err)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch   (perf_fetch),
        .perf_stall   (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents
    function automatic logic [31:0] imem_word(input logic [63:0] a);
        if (a == 64'd40) return 32'h06402083;
        if (a == 64'd64) return 32'h005080B3;
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    always_comb imem_instr = imem_word(imem_addr);

    // ---------------- reference model (queue based) ----------------
    // m_st: 0 IDLE, 1 RUN, 2 DONE, 3 HALT
    int          m_st;
    logic [63:0] m_pc;
    logic [63:0] mq_pc[$];
    logic [31:0] mq_ins[$];
    logic [63:0] m_last_pc;
    logic [31:0] m_last_ins;
    logic        m_err;
    longint      m_fetch;
    longint      m_stall;

    task automatic model_step();
        bit pop_now, redir_now, full_now;
        if (reset) begin
            m_st = 0; m_pc = RESET_PC; mq_pc.delete(); mq_ins.delete();
            m_last_pc = '0; m_last_ins = '0; m_err = 1'b0;
            m_fetch = 0; m_stall = 0;
            return;
        end
        full_now  = (mq_pc.size() == DEPTH);
        pop_now   = (mq_pc.size() > 0) && id_ready;
        redir_now = redir_valid && (m_st == 1 || m_st == 2);
        if (m_st == 1 && full_now && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (pop_now) begin
            void'(mq_pc.pop_front());
            void'(mq_ins.pop_front());
        end
        if (redir_now) begin
            mq_pc.delete(); mq_ins.delete();
            if (redir_pc[1:0] == 2'b00) begin
                m_pc = redir_pc; m_st = 1;
            end else begin
                m_err = 1'b1; m_st = 3;
            end
        end else if (m_st == 1 && !full_now) begin
            mq_pc.push_back(m_pc);
            mq_ins.push_back(imem_word(m_pc));
            if (m_fetch < 64'hFFFF_FFFF) m_fetch++;
            if (m_pc == END_PC) m_st = 2;
            m_pc = m_pc + 64'd4;
        end else if (m_st == 0 && start) begin
            m_st = 1;
        end
        if (mq_pc.size() > 0) begin
            m_last_pc  = mq_pc[0];
            m_last_ins = mq_ins[0];
        end
    endtask

    function automatic logic [162:0] exp_vec();
        return {mq_pc.size() > 0, m_last_pc, m_last_ins,
                (m_st == 1) || (mq_pc.size() > 0), m_err, m_pc};
    endfunction

    function automatic logic [162:0] act_vec();
        return {id_valid, id_pc, id_instr, busy, misalign_err, imem_addr};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; start = 1'b0; redir_valid = 1'b0; redir_pc = '0; id_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1; start = 1'b1; redir_valid = 1'b1; redir_pc = 64'd64; id_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({id_valid, id_pc, id_instr, busy, misalign_err, imem_addr} !==
            {1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 64'd40}) begin
            failures++;
            $display("FAIL reset_state actual=%h required=%h", act_vec(),
                     {1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 64'd40});
        end
`ifdef FETCH_PERF_EN
        checks++;
        if ({perf_fetch, perf_stall} !== 64'd0) begin
            failures++;
            $display("FAIL reset_perf actual=%h required=0", {perf_fetch, perf_stall});
        end
`endif
        idle_inputs();
        redir_valid = 1'b1; redir_pc = 64'd64;
        tick();
        checks++;
        if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL idle_ignores_redirect actual=%h required=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_program();
        logic [63:0] seen[$];
        idle_inputs(); reset = 1'b1; tick();
        idle_inputs(); start = 1'b1; tick();
        checks++;
        if ({id_valid, busy} !== 2'b01) begin
            failures++;
            $display("FAIL start_latency_n actual=%b required=01", {id_valid, busy});
        end
        start = 1'b0; id_ready = 1'b1;
        tick();
        checks++;
        if ({id_valid, id_pc, id_instr} !== {1'b1, 64'd40, 32'h06402083}) begin
            failures++;
            $display("FAIL first_fetch actual=%h required=%h", {id_valid, id_pc, id_instr},
                     {1'b1, 64'd40, 32'h06402083});
        end
        for (int i = 0; i < 20; i++) begin
            if (id_valid && id_ready) seen.push_back(id_pc);
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL program_cycle%0d actual=%h required=%h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if (seen.size() != 12) begin
            failures++;
            $display("FAIL program_count actual=%0d required=12", seen.size());
        end
        for (int i = 0; i < seen.size() && i < 12; i++) begin
            checks++;
            if (seen[i] !== 64'd40 + 64'(4 * i)) begin
                failures++;
                $display("FAIL program_pc%0d actual=%0d required=%0d", i, seen[i], 40 + 4 * i);
            end
        end
        checks++;
        if ({busy, id_valid, imem_addr} !== {1'b0, 1'b0, 64'd88}) begin
            failures++;
            $display("FAIL program_done actual=%h required=%h", {busy, id_valid, imem_addr},
                     {1'b0, 1'b0, 64'd88});
        end
    endtask

    task automatic test_stall();
        idle_inputs(); reset = 1'b1; tick();
        idle_inputs(); start = 1'b1; tick();
        start = 1'b0; id_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if ({id_valid, id_pc, imem_addr} !== {1'b1, 64'd40, 64'd48}) begin
            failures++;
            $display("FAIL stall_hold actual=%h required=%h", {id_valid, id_pc, imem_addr},
                     {1'b1, 64'd40, 64'd48});
        end
        checks++;
        if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL stall_model actual=%h required=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_redirect();
        bit reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            id_ready = (mq_pc.size() > 0) && (mq_pc[0] < 64'd52);
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL redirect_fill%0d actual=%h required=%h", i, act_vec(), exp_vec());
            end
            reached = (mq_pc.size() == 2) && (mq_pc[0] == 64'd52) && (mq_pc[1] == 64'd56);
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("FAIL redirect_setup actual=not_reached required=queue_52_56");
        end
        id_ready = 1'b0; redir_valid = 1'b1; redir_pc = 64'd64;
        tick();
        redir_valid = 1'b0;
        checks++;
        if ({id_valid, imem_addr, busy} !== {1'b0, 64'd64, 1'b1}) begin
            failures++;
            $display("FAIL redirect_flush actual=%h required=%h", {id_valid, imem_addr, busy},
                     {1'b0, 64'd64, 1'b1});
        end
        tick();
        checks++;
        if ({id_valid, id_pc, id_instr} !== {1'b1, 64'd64, 32'h005080B3}) begin
            failures++;
            $display("FAIL redirect_target actual=%h required=%h", {id_valid, id_pc, id_instr},
                     {1'b1, 64'd64, 32'h005080B3});
        end
    endtask

    task automatic test_misalign();
        logic [63:0] pc_before;
        pc_before = imem_addr;
        redir_valid = 1'b1; redir_pc = 64'd66;
        tick();
        redir_valid = 1'b0;
        checks++;
        if ({misalign_err, id_valid, busy, imem_addr} !== {1'b1, 1'b0, 1'b0, pc_before}) begin
            failures++;
            $display("FAIL misalign_halt actual=%h required=%h",
                     {misalign_err, id_valid, busy, imem_addr}, {1'b1, 1'b0, 1'b0, pc_before});
        end
        start = 1'b1; id_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        start = 1'b0;
        checks++;
        if ({misalign_err, id_valid, busy, imem_addr} !== {1'b1, 1'b0, 1'b0, pc_before}) begin
            failures++;
            $display("FAIL misalign_stays actual=%h required=%h",
                     {misalign_err, id_valid, busy, imem_addr}, {1'b1, 1'b0, 1'b0, pc_before});
        end
    endtask

    task automatic test_reset_mid_run();
        idle_inputs(); reset = 1'b1; tick();
        idle_inputs(); start = 1'b1; tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1; start = 1'b1; redir_valid = 1'b1; redir_pc = 64'd64; id_ready = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if ({imem_addr, id_valid, busy, misalign_err} !== {64'd40, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_run actual=%h required=%h",
                     {imem_addr, id_valid, busy, misalign_err}, {64'd40, 1'b0, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if ({busy, imem_addr} !== {1'b0, 64'd40}) begin
            failures++;
            $display("FAIL reset_mid_run_idle actual=%h required=%h", {busy, imem_addr},
                     {1'b0, 64'd40});
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        idle_inputs(); reset = 1'b1; tick();
        idle_inputs(); start = 1'b1; tick();
        start = 1'b0; id_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        id_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if ({perf_fetch, perf_stall} !== {32'd12, 32'd3}) begin
            failures++;
            $display("FAIL perf_counts actual=%0d/%0d required=12/3", perf_fetch, perf_stall);
        end
    endtask
`endif

    task automatic test_random();
        logic [63:0] tgt;
        idle_inputs(); reset = 1'b1; tick();
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 59) == 0);
            start       = ($urandom_range(0, 3) == 0);
            id_ready    = ($urandom_range(0, 2) != 0);
            redir_valid = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 15) == 0)
                tgt = 64'hFFFF_FFFF_FFFF_FFF8;
            else
                tgt = 64'($urandom_range(8, 24)) * 64'd4;
            if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            redir_pc = tgt;
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_cycle%0d actual=%h required=%h", i, act_vec(), exp_vec());
            end
`ifdef FETCH_PERF_EN
            checks++;
            if ({perf_fetch, perf_stall} !== {m_fetch[31:0], m_stall[31:0]}) begin
                failures++;
                $display("FAIL random_perf%0d actual=%0d/%0d required=%0d/%0d", i,
                         perf_fetch, perf_stall, m_fetch, m_stall);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_program();
        test_stall();
        test_redirect();
        test_misalign();
        test_reset_mid_run();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
